// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and 48 MHz board constants for the programmable divider
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_e;

    localparam int unsigned CLK_HZ       = 48_000_000;
    localparam int unsigned CNT_W_DEF    = 24;
    localparam int unsigned PERIOD_500HZ = CLK_HZ / 500;
    localparam int unsigned PERIOD_1KHZ  = CLK_HZ / 1000;
    // A 1 Hz period does not fit the default width; instantiate with CNT_W >= 26 for it.
    localparam int unsigned PERIOD_1HZ   = CLK_HZ;
    localparam int unsigned MIN_PERIOD   = 2;

    function automatic int unsigned half_of(input int unsigned period);
        return period / 2;
    endfunction

endpackage

// File: rtl/clk_div_cfg_shadow.sv
// rtl/clk_div_cfg_shadow.sv - load validation, shadow registers and boundary-synchronous apply
module clk_div_cfg_shadow
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned RESET_PERIOD = PERIOD_500HZ,
    parameter int unsigned RESET_HIGH   = half_of(PERIOD_500HZ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] period_in_i,
    input  logic [CNT_W-1:0] high_in_i,
    input  logic             idle_i,
    input  logic             boundary_i,
    output logic [CNT_W-1:0] act_period_o,
    output logic [CNT_W-1:0] act_high_o,
    output logic             pending_o,
    output logic             cfg_err_o
);

    logic [CNT_W-1:0] sh_period_q, sh_period_d;
    logic [CNT_W-1:0] sh_high_q, sh_high_d;
    logic [CNT_W-1:0] act_period_q, act_period_d;
    logic [CNT_W-1:0] act_high_q, act_high_d;
    logic             pending_q, pending_d;
    logic             cfg_err_q, cfg_err_d;
    logic             load_ok;

    assign load_ok = load_i && (period_in_i >= CNT_W'(MIN_PERIOD));

    always_comb begin
        sh_period_d  = sh_period_q;
        sh_high_d    = sh_high_q;
        act_period_d = act_period_q;
        act_high_d   = act_high_q;
        pending_d    = pending_q;
        cfg_err_d    = cfg_err_q;

        if (load_i) begin
            cfg_err_d = !load_ok;
        end

        if (boundary_i) begin
            // A load landing on the last cycle of a period skips the shadow stage.
            if (load_ok) begin
                sh_period_d  = period_in_i;
                sh_high_d    = high_in_i;
                act_period_d = period_in_i;
                act_high_d   = high_in_i;
                pending_d    = 1'b0;
            end else if (pending_q) begin
                act_period_d = sh_period_q;
                act_high_d   = sh_high_q;
                pending_d    = 1'b0;
            end
        end else if (load_ok) begin
            sh_period_d = period_in_i;
            sh_high_d   = high_in_i;
            pending_d   = 1'b1;
        end else if (idle_i && pending_q) begin
            act_period_d = sh_period_q;
            act_high_d   = sh_high_q;
            pending_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_period_q  <= '0;
            sh_high_q    <= '0;
            act_period_q <= CNT_W'(RESET_PERIOD);
            act_high_q   <= CNT_W'(RESET_HIGH);
            pending_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            sh_period_q  <= sh_period_d;
            sh_high_q    <= sh_high_d;
            act_period_q <= act_period_d;
            act_high_q   <= act_high_d;
            pending_q    <= pending_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign act_period_o = act_period_q;
    assign act_high_o   = act_high_q;
    assign pending_o    = pending_q;
    assign cfg_err_o    = cfg_err_q;

endmodule

// File: rtl/clk_divider_prog.sv
// rtl/clk_divider_prog.sv - runtime-programmable glitch-free clock divider with duty control
module clk_divider_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned RESET_PERIOD = PERIOD_500HZ,
    parameter int unsigned RESET_HIGH   = half_of(PERIOD_500HZ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] period_in,
    input  logic [CNT_W-1:0] high_in,
    output logic             clk_div,
    output logic             tick,
    output logic             pending,
    output logic             cfg_err
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             clk_div_q, clk_div_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] act_period;
    logic [CNT_W-1:0] act_high;
    logic             at_end;
    logic             boundary;

    assign at_end   = (count_q == act_period - CNT_W'(1));
    assign boundary = (state_q == RUN) && at_end;

    clk_div_cfg_shadow #(
        .CNT_W       (CNT_W),
        .RESET_PERIOD(RESET_PERIOD),
        .RESET_HIGH  (RESET_HIGH)
    ) u_cfg_shadow (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load),
        .period_in_i (period_in),
        .high_in_i   (high_in),
        .idle_i      (state_q == IDLE),
        .boundary_i  (boundary),
        .act_period_o(act_period),
        .act_high_o  (act_high),
        .pending_o   (pending),
        .cfg_err_o   (cfg_err)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        clk_div_d = 1'b0;
        tick_d    = 1'b0;

        if (state_q == IDLE) begin
            count_d = '0;
            if (en) begin
                state_d = RUN;
            end
        end else if (!en) begin
            // Disabling abandons the partial period rather than finishing it.
            state_d = IDLE;
            count_d = '0;
        end else begin
            clk_div_d = (count_q < act_high);
            tick_d    = (count_q == '0);
            count_d   = at_end ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            clk_div_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            clk_div_q <= clk_div_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_div = clk_div_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// tb/tb_clk_divider_prog.sv - directed scoreboard bench for clk_divider_prog
module tb_clk_divider_prog;

    localparam int CNT_W = 24;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             load;
    logic [CNT_W-1:0] period_in;
    logic [CNT_W-1:0] high_in;
    logic             clk_div;
    logic             tick;
    logic             pending;
    logic             cfg_err;

    int               vectors = 0;
    int               miscompares = 0;
    string            tag = "init";
    logic [3:0]       exp_q[$];

    clk_divider_prog #(
        .CNT_W       (CNT_W),
        .RESET_PERIOD(96000),
        .RESET_HIGH  (48000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .period_in(period_in),
        .high_in  (high_in),
        .clk_div  (clk_div),
        .tick     (tick),
        .pending  (pending),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected vector layout: {clk_div, tick, pending, cfg_err}
    task automatic compare(input logic [3:0] expv);
        logic [3:0] obs;
        obs = {clk_div, tick, pending, cfg_err};
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s vec %0d: observed %b expected %b", tag, vectors, obs, expv);
        end
    endtask

    task automatic check_now();
        compare(exp_q.pop_front());
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            step();
            compare(exp_q.pop_front());
        end
    endtask

    task automatic push_const(input logic [3:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic push_period(input int per, input int hi, input int first, input int n,
                               input logic pend, input logic err);
        int c;
        for (int i = 0; i < n; i++) begin
            c = (first + i) % per;
            exp_q.push_back({(c < hi), (c == 0), pend, err});
        end
    endtask

    task automatic load_cycle(input int p, input int h, input logic [3:0] expv);
        load      = 1'b1;
        period_in = CNT_W'(p);
        high_in   = CNT_W'(h);
        exp_q.push_back(expv);
        drain();
        load = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        en        = 1'b0;
        load      = 1'b0;
        period_in = '0;
        high_in   = '0;

        tag = "reset_state";
        #12;
        exp_q.push_back(4'b0000);
        check_now();
        #10 reset = 1'b0;
        step();

        tag = "default_500hz";
        en = 1'b1;
        exp_q.push_back(4'b0000);
        push_period(96000, 48000, 0, 48002, 1'b0, 1'b0);
        drain();

        tag = "disable_mid_period";
        en = 1'b0;
        exp_q.push_back(4'b0000);
        drain();

        tag = "load_idle";
        load_cycle(10, 3, 4'b0010);
        exp_q.push_back(4'b0000);
        drain();
        en = 1'b1;
        exp_q.push_back(4'b0000);
        push_period(10, 3, 0, 30, 1'b0, 1'b0);
        drain();

        tag = "mid_period_load";
        push_period(10, 3, 0, 4, 1'b0, 1'b0);
        drain();
        load_cycle(6, 1, 4'b0010);
        push_const(4'b0010, 4);
        exp_q.push_back(4'b0000);
        push_period(6, 1, 0, 12, 1'b0, 1'b0);
        drain();

        tag = "bad_load";
        load_cycle(1, 5, 4'b1101);
        push_period(6, 1, 1, 11, 1'b0, 1'b1);
        drain();

        tag = "good_load_clears_err";
        load_cycle(4, 2, 4'b1110);
        push_const(4'b0010, 4);
        exp_q.push_back(4'b0000);
        push_period(4, 2, 0, 8, 1'b0, 1'b0);
        drain();

        tag = "boundary_bypass_high0";
        push_period(4, 2, 0, 3, 1'b0, 1'b0);
        drain();
        load_cycle(10, 0, 4'b0000);
        push_period(10, 0, 0, 20, 1'b0, 1'b0);
        drain();

        tag = "high_over_period";
        load_cycle(10, 12, 4'b0110);
        push_const(4'b0010, 8);
        exp_q.push_back(4'b0000);
        push_period(10, 12, 0, 20, 1'b0, 1'b0);
        drain();

        tag = "async_reset";
        load_cycle(6, 1, 4'b1110);
        push_const(4'b1010, 8);
        exp_q.push_back(4'b1000);
        push_period(6, 1, 0, 1, 1'b0, 1'b0);
        drain();
        #3 reset = 1'b1;
        #1;
        exp_q.push_back(4'b0000);
        check_now();
        #2 reset = 1'b0;

        tag = "defaults_restored";
        exp_q.push_back(4'b0000);
        push_period(96000, 48000, 0, 20, 1'b0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
